// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd4;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE,
    SHIFT
  } conv_state_t;
endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble step: add 3 to every digit above 4, then shift bit_in in.
// Zero latency; no handshake, the caller sequences the steps.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic [DIGIT_W*NDIG-1:0] acc,
  input  logic                    bit_in,
  output logic [DIGIT_W*NDIG-1:0] acc_next,
  output logic                    carry
);
  logic [DIGIT_W*NDIG-1:0] adj;
  bcd_digit_t              d;

  always_comb begin
    adj = acc;
    d   = '0;
    for (int k = 0; k < NDIG; k++) begin
      d = acc[DIGIT_W*k +: DIGIT_W];
      if (d > ADD3_THRESH) d = d + 4'd3;
      adj[DIGIT_W*k +: DIGIT_W] = d;
    end
  end

  // The bit leaving the top digit would belong to digit NDIG, i.e. the value overflowed.
  assign acc_next = {adj[DIGIT_W*NDIG-2:0], bit_in};
  assign carry    = adj[DIGIT_W*NDIG-1];
endmodule

// File: rtl/bcd_conv_seq.sv
// Bit-serial binary-to-BCD converter, one bit per clock, result BIN_W+1 cycles after accept;
// in_ready drops while busy. Leading-zero blanking enabled by BCD_CONV_LZ_BLANK_EN.
module bcd_conv_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14,
  parameter int NDIG  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_W-1:0]        bin,
  output logic                    out_valid,
  output logic [DIGIT_W*NDIG-1:0] bcd,
  output logic                    overflow,
  output logic [NDIG-1:0]         blank
);
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t             state;
  logic [CNT_W-1:0]        cnt;
  logic [BIN_W-1:0]        bin_sr;
  logic [DIGIT_W*NDIG-1:0] acc;
  logic                    ovf_sticky;

  logic [DIGIT_W*NDIG-1:0] acc_next;
  logic                    carry;
  logic                    ovf_next;

  bcd_dabble_step #(.NDIG(NDIG)) u_step (
    .acc      (acc),
    .bit_in   (bin_sr[BIN_W-1]),
    .acc_next (acc_next),
    .carry    (carry)
  );

  assign ovf_next = ovf_sticky | carry;

`ifdef BCD_CONV_LZ_BLANK_EN
  logic [NDIG-1:0] blank_next;
  logic            all_zero;

  // Digit 0 is never blanked so a zero value still shows a single "0".
  always_comb begin
    blank_next = '0;
    all_zero   = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      all_zero      = all_zero & (acc_next[DIGIT_W*k +: DIGIT_W] == '0);
      blank_next[k] = all_zero;
    end
    if (ovf_next) blank_next = '0;
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      bcd        <= '0;
      overflow   <= 1'b0;
      cnt        <= '0;
      bin_sr     <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
`ifdef BCD_CONV_LZ_BLANK_EN
      blank      <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            bin_sr     <= bin;
            acc        <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= CNT_W'(BIN_W);
            in_ready   <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          bin_sr     <= bin_sr << 1;
          acc        <= acc_next;
          ovf_sticky <= ovf_next;
          cnt        <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd       <= acc_next;
            overflow  <= ovf_next;
`ifdef BCD_CONV_LZ_BLANK_EN
            blank     <= blank_next;
`endif
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_conv_seq.sv
// Scoreboard bench for bcd_conv_seq: a 4-digit and a 5-digit instance share one request stream.
module tb_bcd_conv_seq;
  localparam int BIN_W = 14;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic [13:0] bin = '0;

  logic        in_ready, out_valid, overflow;
  logic [15:0] bcd;
  logic [3:0]  blank;
  logic        in_ready5, out_valid5, overflow5;
  logic [19:0] bcd5;
  logic [4:0]  blank5;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int lowrun = 0;
  int ov_prev = 0;
  int ov_last = 0;
  logic [15:0] hold_exp = '0;

  typedef struct {
    logic [19:0] b;
    logic        o;
    logic [4:0]  bl;
    int          cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];

  bcd_conv_seq #(.BIN_W(14), .NDIG(4)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .bcd(bcd), .overflow(overflow), .blank(blank)
  );

  bcd_conv_seq #(.BIN_W(14), .NDIG(5)) dut5 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready5), .bin(bin),
    .out_valid(out_valid5), .bcd(bcd5), .overflow(overflow5), .blank(blank5)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int v, input int nd, input int c);
    exp_t e;
    int   t;
    logic above;
    e.b = '0; e.bl = '0; e.cyc = c;
    t = v;
    for (int k = 0; k < nd; k++) begin
      e.b[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    e.o = (t != 0);
`ifdef BCD_CONV_LZ_BLANK_EN
    above = 1'b1;
    if (!e.o) begin
      for (int k = nd - 1; k >= 1; k--) begin
        above = above & (e.b[4*k +: 4] == 4'd0);
        e.bl[k] = above;
      end
    end
`else
    above = 1'b0;
    e.bl[0] = above;
`endif
    return e;
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      q4.delete();
      q5.delete();
      lowrun   = 0;
      hold_exp = '0;
    end else begin
      if (out_valid) begin
        ov_prev = ov_last;
        ov_last = cyc;
        if (q4.size() == 0) check("spurious_out_valid", 32'(out_valid), 32'd0);
        else begin
          e = q4.pop_front();
          check("bcd4", 32'(bcd), 32'(e.b[15:0]));
          check("ovf4", 32'(overflow), 32'(e.o));
          check("blank4", 32'(blank), 32'(e.bl[3:0]));
          check("latency", 32'(cyc - e.cyc), 32'(BIN_W + 1));
          hold_exp = e.b[15:0];
        end
      end else if (!in_ready) begin
        check("hold_bcd4", 32'(bcd), 32'(hold_exp));
      end
      if (out_valid5) begin
        if (q5.size() == 0) check("spurious_out_valid5", 32'(out_valid5), 32'd0);
        else begin
          e = q5.pop_front();
          check("bcd5", 32'(bcd5), 32'(e.b));
          check("ovf5", 32'(overflow5), 32'(e.o));
          check("blank5", 32'(blank5), 32'(e.bl));
        end
      end
      if (!in_ready) lowrun++;
      else if (lowrun != 0) begin
        check("ready_low_cycles", 32'(lowrun), 32'(BIN_W));
        lowrun = 0;
      end
      if (in_valid && in_ready) begin
        q4.push_back(model(int'(bin), 4, cyc));
        q5.push_back(model(int'(bin), 5, cyc));
      end
    end
  end

  // Present a request and hold it until the converter takes it.
  task automatic send(input int v);
    int n;
    bin = 14'(v);
    in_valid = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!in_ready && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    @(negedge CLK);
    while (!out_valid && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (!out_valid) check("out_timeout", 32'(out_valid), 32'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_bcd"}, 32'(bcd), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_blank"}, 32'(blank), 32'd0);
  endtask

  initial begin
    #3 RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 check_reset_outputs("reset");
    @(posedge CLK);
    #1 RST = 1'b0;

    send(9999);  in_valid = 1'b0; wait_out();
    send(0);     in_valid = 1'b0; wait_out();
    send(42);    in_valid = 1'b0; wait_out();
    send(16383); in_valid = 1'b0; wait_out();

    // Back-to-back with in_valid held high throughout.
    send(123);
    send(4567);
    in_valid = 1'b0;
    wait_out();
    check("b2b_gap", 32'(ov_last - ov_prev), 32'(BIN_W + 1));

    // Reset in the middle of a conversion.
    send(9999);
    in_valid = 1'b0;
    repeat (6) @(posedge CLK);
    #1 RST = 1'b1;
    #1 check_reset_outputs("abort");
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    send(77); in_valid = 1'b0; wait_out();

    // Input changes while busy must not disturb the accepted value.
    send(500);
    bin = 14'd1234; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      #1 in_valid = ~in_valid;
      bin = 14'($urandom_range(0, 16383));
    end
    in_valid = 1'b0;
    wait_out();

    for (int i = 0; i < 6; i++) begin
      send(int'($urandom_range(0, 16383)));
      in_valid = 1'b0;
      wait_out();
    end

    repeat (3) @(posedge CLK);
    #1;
    check("queue_drained", 32'(q4.size() + q5.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 32'd1, 32'(cyc < 0));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
